// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit for the execute stage.
// A multiply takes a single cycle in MUL. A divide runs a radix-2 restoring
// loop on operand magnitudes for DIV_CYCLES cycles, then FIX applies signs.
// busy stalls the pipeline, done pulses for one cycle when hi/lo are written,
// and flush aborts any in-flight operation without touching hi/lo.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; latches op and operands on accept
// MUL   | full 64-bit product written to hi/lo, done pulsed
// DIV   | one quotient bit per cycle on operand magnitudes
// FIX   | apply signs / divide-by-zero result, write hi/lo, done

module mul_div_unit #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [1:0] OP_DIV = 2'b10;

    localparam int              CNT_W    = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    logic [1:0]       state;
    logic [1:0]       op_r;
    logic [31:0]      a_r;
    logic [31:0]      b_r;
    logic [31:0]      quo;
    logic [31:0]      rem;
    logic [31:0]      dvs;
    logic [CNT_W-1:0] cnt;

    logic        accept;
    logic        is_sdiv;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign busy    = (state != S_IDLE);
    assign accept  = (state == S_IDLE) && start && !flush;
    assign is_sdiv = (op_r == OP_DIV);

    // Operand conditioning, product, restoring-divide step and sign fix-up.
    always_comb begin
        abs_a   = ((op == OP_DIV) && src_a[31]) ? (32'd0 - src_a) : src_a;
        abs_b   = ((op == OP_DIV) && src_b[31]) ? (32'd0 - src_b) : src_b;
        a_ext   = op_r[0] ? {32'd0, a_r} : {{32{a_r[31]}}, a_r};
        b_ext   = op_r[0] ? {32'd0, b_r} : {{32{b_r[31]}}, b_r};
        product = a_ext * b_ext;
        shifted = {rem, quo[31]};
        diff    = shifted - {1'b0, dvs};
        // Quotient negated on sign mismatch; remainder follows the dividend.
        quo_fix = (is_sdiv && (a_r[31] ^ b_r[31])) ? (32'd0 - quo) : quo;
        rem_fix = (is_sdiv && a_r[31]) ? (32'd0 - rem) : rem;
    end

    // Sequencer plus datapath registers; flush aborts without writing hi/lo.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            op_r  <= 2'd0;
            a_r   <= 32'd0;
            b_r   <= 32'd0;
            quo   <= 32'd0;
            rem   <= 32'd0;
            dvs   <= 32'd0;
            cnt   <= '0;
            done  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_r  <= op;
                        a_r   <= src_a;
                        b_r   <= src_b;
                        quo   <= abs_a;
                        dvs   <= abs_b;
                        rem   <= 32'd0;
                        cnt   <= '0;
                        state <= op[1] ? S_DIV : S_MUL;
                    end
                end
                S_MUL: begin
                    state <= S_IDLE;
                    if (!flush) begin
                        hi   <= product[63:32];
                        lo   <= product[31:0];
                        done <= 1'b1;
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        if (!diff[32]) begin
                            rem <= diff[31:0];
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= shifted[31:0];
                            quo <= {quo[30:0], 1'b0};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    if (!flush) begin
                        // A zero divisor returns all-ones quotient and the raw dividend.
                        if (b_r == 32'd0) begin
                            hi <= a_r;
                            lo <= 32'hFFFF_FFFF;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                        done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random
// operations compared against an arithmetic reference model.

module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mul_div_unit #(.DIV_CYCLES(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Reference: {hi, lo} from plain arithmetic on the operands.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        int              da;
        int              db;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        da = a;
        db = b;
        case (o)
            2'd0: model = sa * sb;
            2'd1: model = ua * ub;
            2'd2: begin
                if (b == 32'd0)
                    model = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    model = {32'd0, 32'h8000_0000};
                else
                    model = {32'(da % db), 32'(da / db)};
            end
            default: begin
                if (b == 32'd0)
                    model = {a, 32'hFFFF_FFFF};
                else
                    model = {a % b, a / b};
            end
        endcase
    endfunction

    // Issue one operation and follow it to done, checking busy, latency and result.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit no_wait, input int poke_k, input string name);
        logic [63:0] m;
        int lat;
        int got;
        m   = model(o, a, b);
        lat = o[1] ? 34 : 2;
        if (!no_wait) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        src_a = $urandom;
        src_b = $urandom;
        got   = 0;
        for (int k = 1; k <= lat + 3 && got == 0; k++) begin
            @(negedge clk);
            if (k == poke_k) begin
                start = 1'b1;
                op    = 2'($urandom);
                src_a = $urandom;
                src_b = $urandom;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                got = k;
                vectors++;
                if (k != lat) begin
                    miscompares++;
                    $display("FAIL %s latency: got %0d want %0d", name, k, lat);
                end
                vectors++;
                if ({busy, hi, lo} !== {1'b0, m}) begin
                    miscompares++;
                    $display("FAIL %s result: got busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h",
                             name, busy, hi, lo, m[63:32], m[31:0]);
                end
                exp_hi = m[63:32];
                exp_lo = m[31:0];
            end else begin
                vectors++;
                if ({busy, hi, lo} !== {1'b1, exp_hi, exp_lo}) begin
                    miscompares++;
                    $display("FAIL %s in-flight cycle %0d: got busy=%b hi=%h lo=%h want busy=1 hi=%h lo=%h",
                             name, k, busy, hi, lo, exp_hi, exp_lo);
                end
            end
        end
        start = 1'b0;
        if (got == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: got no done want done at cycle %0d", name, lat);
        end
    endtask

    // Start an operation and flush it in cycle k after accept; leaves time at cycle k+1 negedge.
    task automatic flush_at(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input int k, input string name);
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        for (int j = 1; j <= k; j++) begin
            @(negedge clk);
            vectors++;
            if ({busy, done, hi, lo} !== {2'b10, exp_hi, exp_lo}) begin
                miscompares++;
                $display("FAIL %s pre-flush cycle %0d: got busy=%b done=%b hi=%h lo=%h want busy=1 done=0 hi=%h lo=%h",
                         name, j, busy, done, hi, lo, exp_hi, exp_lo);
            end
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        vectors++;
        if ({busy, done, hi, lo} !== {2'b00, exp_hi, exp_lo}) begin
            miscompares++;
            $display("FAIL %s post-flush: got busy=%b done=%b hi=%h lo=%h want busy=0 done=0 hi=%h lo=%h",
                     name, busy, done, hi, lo, exp_hi, exp_lo);
        end
    endtask

    // Watch n cycles with no operation in flight: no done, idle, hi/lo held.
    task automatic watch_quiet(input int n, input string name);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            vectors++;
            if ({busy, done, hi, lo} !== {2'b00, exp_hi, exp_lo}) begin
                miscompares++;
                $display("FAIL %s quiet cycle %0d: got busy=%b done=%b hi=%h lo=%h want busy=0 done=0 hi=%h lo=%h",
                         name, j, busy, done, hi, lo, exp_hi, exp_lo);
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'd0;
        src_a = 32'd0;
        src_b = 32'd0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            miscompares++;
            $display("FAIL reset: got busy=%b done=%b hi=%h lo=%h want all zero", busy, done, hi, lo);
        end
        rst = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        watch_quiet(2, "reset_idle");
    endtask

    task automatic test_mul();
        run_op(2'd0, 32'hFFFF_FFFE, 32'd3, 0, 0, "mult_neg2x3");
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multu_max");
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 0, 0, "mult_minxmin");
    endtask

    task automatic test_div();
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, "div_neg7by2");
        run_op(2'd3, 32'd7, 32'd2, 0, 0, "divu_7by2");
        run_op(2'd2, 32'd7, 32'hFFFF_FFFE, 0, 0, "div_7byneg2");
    endtask

    task automatic test_div_corners();
        run_op(2'd3, 32'h1234_5678, 32'd0, 0, 0, "divu_by_zero");
        run_op(2'd2, 32'hFFFF_FFF0, 32'd0, 0, 0, "div_neg_by_zero");
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_overflow");
        run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "divu_small_quot");
    endtask

    task automatic test_start_while_busy();
        run_op(2'd2, 32'hDEAD_BEEF, 32'h0000_1234, 0, 5, "div_start_ignored");
        run_op(2'd0, 32'h0000_7FFF, 32'hFFFF_8000, 0, 1, "mul_start_ignored");
    endtask

    task automatic test_back_to_back();
        run_op(2'd0, 32'h0001_0001, 32'h0002_0003, 0, 0, "b2b_mult");
        run_op(2'd2, 32'hFFFF_FF00, 32'd7, 1, 0, "b2b_div");
        run_op(2'd1, 32'hCAFE_F00D, 32'h1357_9BDF, 1, 0, "b2b_multu");
    endtask

    task automatic test_flush();
        flush_at(2'd2, 32'h0BAD_CAFE, 32'd3, 10, "flush_div_c10");
        run_op(2'd1, 32'h0000_FFFF, 32'h0001_0000, 1, 0, "multu_after_flush");
        watch_quiet(30, "aborted_div_silent");
        flush_at(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1, "flush_mul_done_cycle");
        watch_quiet(3, "after_flush_mul");
        flush_at(2'd3, 32'h7777_7777, 32'd5, 33, "flush_fix_done_cycle");
        watch_quiet(3, "after_flush_fix");
        // flush and start together in IDLE: request must not be accepted
        @(posedge clk);
        #1;
        start = 1'b1;
        flush = 1'b1;
        op    = 2'd1;
        src_a = 32'h0000_0005;
        src_b = 32'h0000_0006;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        watch_quiet(4, "flush_beats_start");
    endtask

    task automatic test_random(input int n);
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        int sel;
        for (int i = 0; i < n; i++) begin
            o   = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) b = 32'($urandom_range(1, 15));
            else if (sel == 2 && o == 2'd2) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            run_op(o, a, b, ($urandom_range(0, 1) == 1), 0, "random");
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'd2;
        src_a = 32'h0F0F_0F0F;
        src_b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            miscompares++;
            $display("FAIL reset_mid async: got busy=%b done=%b hi=%h lo=%h want all zero",
                     busy, done, hi, lo);
        end
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        watch_quiet(40, "reset_mid_silent");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_corners();
        test_start_while_busy();
        test_back_to_back();
        test_flush();
        test_random(24);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
